mul_share_rr_sched: RTL

//  Shares one pipelined signed multiplier (14s x 9s -> 23s, 2-cycle latency, clock-enable

---
 rtl/mul_share_rr_sched.sv | 115 +++++++++++
 1 files changed

// File: rtl/mul_share_rr_sched.sv
// Round-robin scheduler sharing one 2-stage signed multiplier among NREQ requesters,
// with requester-id tags carried alongside the product and a valid/ready result port.
module mul_share_rr_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned A_W  = 14,
  parameter int unsigned B_W  = 9,
  parameter int unsigned P_W  = 23,
  localparam int unsigned ID_W = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*A_W-1:0]   req_a,
  input  logic [NREQ*B_W-1:0]   req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [P_W-1:0]        res_data,
  output logic [ID_W-1:0]       res_id,
  output logic                  busy
);

  logic                   advance;
  logic                   found;
  logic                   accept;
  logic [ID_W-1:0]        ptr;
  logic [ID_W-1:0]        grant;
  logic [ID_W-1:0]        cand;
  int unsigned            idx;
  logic signed [A_W-1:0]  a_arr [NREQ];
  logic signed [B_W-1:0]  b_arr [NREQ];
  logic signed [A_W-1:0]  sel_a;
  logic signed [B_W-1:0]  sel_b;
  logic signed [A_W-1:0]  a_q;
  logic signed [B_W-1:0]  b_q;
  logic signed [P_W-1:0]  a_ext;
  logic signed [P_W-1:0]  b_ext;
  logic signed [P_W-1:0]  p_q;
  logic                   vld0;
  logic                   vld1;
  logic [ID_W-1:0]        id0;
  logic [ID_W-1:0]        id1;

  for (genvar i = 0; i < NREQ; i++) begin : g_split
    assign a_arr[i] = req_a[i*A_W +: A_W];
    assign b_arr[i] = req_b[i*B_W +: B_W];
  end

  // The whole pipe moves only when the output slot is empty or being drained.
  assign advance = !vld1 || res_ready;
  assign accept  = advance && found;

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = ID_W'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  assign sel_a = a_arr[grant];
  assign sel_b = b_arr[grant];

  // Control and tag pipe; flushing on reset discards anything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr  <= '0;
      vld0 <= 1'b0;
      vld1 <= 1'b0;
      id0  <= '0;
      id1  <= '0;
      busy <= 1'b0;
    end else begin
      if (accept) ptr <= (grant == ID_W'(NREQ - 1)) ? '0 : grant + ID_W'(1);
      if (advance) begin
        vld0 <= accept;
        id0  <= grant;
        vld1 <= vld0;
        id1  <= id0;
        busy <= accept || vld0;
      end
    end
  end

  assign a_ext = P_W'(a_q);
  assign b_ext = P_W'(b_q);

  // Multiplier datapath shares the same enable so products stay aligned with tags.
  always_ff @(posedge clk) begin
    if (advance) begin
      a_q <= sel_a;
      b_q <= sel_b;
      p_q <= a_ext * b_ext;
    end
  end

  assign res_valid = vld1;
  assign res_id    = id1;
  assign res_data  = p_q;

endmodule
